// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and types for the FND scan driver
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] COM_OFF   = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational nibble to active-low 7-segment pattern
module seg7_hex_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - 4-digit common-anode FND scanner with frame latch, blink and guard
// Optional build macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int GUARD       = 2,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  com,
  output logic [7:0]  seg_7,
  output logic        frame_tick
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SCW:0] GUARD_W = (SCW + 1)'(GUARD);

  logic [SCW-1:0] scan_cnt;
  digit_idx_t     digit_idx;
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;
  logic [15:0]    frame_val;
  logic [3:0]     frame_dp;
  logic [3:0]     frame_mask;

  logic           tick;
  logic           in_guard;
  logic [3:0]     nibble;
  logic [6:0]     hex_seg;
  logic [3:0]     lz_blank;
  logic           blink_blank;

  assign tick     = (scan_cnt == SCW'(SCAN_DIV - 1));
  assign in_guard = ({1'b0, scan_cnt} < GUARD_W);

  always_comb begin
    nibble = frame_val[3:0];
    case (digit_idx)
      2'd0: nibble = frame_val[3:0];
      2'd1: nibble = frame_val[7:4];
      2'd2: nibble = frame_val[11:8];
      2'd3: nibble = frame_val[15:12];
      default: nibble = frame_val[3:0];
    endcase
  end

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (hex_seg)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  // A digit is blanked only if it and every digit to its left are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (frame_val[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (frame_val[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (frame_val[7:4] == 4'h0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  assign blink_blank = ~blink_phase & frame_mask[digit_idx];

  always_ff @(posedge clk) begin
    if (reset_p) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      frame_val   <= '0;
      frame_dp    <= '0;
      frame_mask  <= '0;
      com         <= COM_OFF;
      seg_7       <= SEG_BLANK;
      frame_tick  <= 1'b0;
    end else begin
      scan_cnt   <= tick ? '0 : scan_cnt + SCW'(1);
      frame_tick <= tick && (digit_idx == 2'd3);

      if (tick) begin
        digit_idx <= digit_idx + 2'd1;
        if (digit_idx == 2'd3) begin
          frame_val  <= value;
          frame_dp   <= dp_in;
          frame_mask <= blink_mask;
        end
        if (blink_cnt == BCW'(BLINK_TICKS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BCW'(1);
        end
      end

      com <= in_guard ? COM_OFF : ~(4'b0001 << digit_idx);

      if (blink_blank)
        seg_7 <= SEG_BLANK;
      else if (lz_blank[digit_idx])
        seg_7 <= {~frame_dp[digit_idx], 7'h7F};
      else
        seg_7 <= {~frame_dp[digit_idx], hex_seg};
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb/tb_fnd_scan_driver.sv - directed self-checking bench for fnd_scan_driver
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic [3:0]  com;
  logic [7:0]  seg_7;
  logic        frame_tick;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  fnd_scan_driver #(.SCAN_DIV(4), .GUARD(1), .BLINK_TICKS(2)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .value      (value),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .com        (com),
    .seg_7      (seg_7),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; outputs sampled 1 time unit after the edge.
  task automatic go(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_p = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset_p = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    value = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0000;
    apply_reset();
    vectors++; if (com !== 4'b1111) begin miscompares++; $display("FAIL reset_com got %b want 1111", com); end
    vectors++; if (seg_7 !== 8'hFF) begin miscompares++; $display("FAIL reset_seg got %h want ff", seg_7); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_ftick got %b want 0", frame_tick); end
    release_reset();
    go(1);
    vectors++; if (com !== 4'b1111) begin miscompares++; $display("FAIL first_guard_com got %b want 1111", com); end
    vectors++; if (seg_7 !== 8'hC0) begin miscompares++; $display("FAIL first_guard_seg got %h want c0", seg_7); end
    go(2);
    vectors++; if (com !== 4'b1110) begin miscompares++; $display("FAIL first_d0_com got %b want 1110", com); end
    vectors++; if (seg_7 !== 8'hC0) begin miscompares++; $display("FAIL first_d0_seg got %h want c0", seg_7); end
  endtask

  task automatic test_first_latch();
    go(15);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL pre_latch_ftick got %b want 0", frame_tick); end
    go(16);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL latch_ftick got %b want 1", frame_tick); end
    go(17);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL post_latch_ftick got %b want 0", frame_tick); end
    vectors++; if (com !== 4'b1111) begin miscompares++; $display("FAIL f1_guard_com got %b want 1111", com); end
    go(18);
    vectors++; if (com !== 4'b1110) begin miscompares++; $display("FAIL f1_d0_com got %b want 1110", com); end
    vectors++; if (seg_7 !== 8'h99) begin miscompares++; $display("FAIL f1_d0_seg got %h want 99", seg_7); end
    go(30);
    vectors++; if (com !== 4'b0111) begin miscompares++; $display("FAIL f1_d3_com got %b want 0111", com); end
    vectors++; if (seg_7 !== 8'hF9) begin miscompares++; $display("FAIL f1_d3_seg got %h want f9", seg_7); end
  endtask

  task automatic test_guard();
    logic [3:0] exp_com;
    for (int i = 0; i < 16; i++) begin
      go(33 + i);
      if (i % 4 == 0) exp_com = 4'b1111;
      else            exp_com = ~(4'b0001 << (i / 4));
      vectors++;
      if (com !== exp_com) begin
        miscompares++;
        $display("FAIL guard_com slot_cycle %0d got %b want %b", i, com, exp_com);
      end
    end
  endtask

  task automatic test_value_change();
    logic [7:0] exp_seg [4];
    exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    go(50);
    value = 16'hABCD;
    go(58);
    vectors++; if (com !== 4'b1011) begin miscompares++; $display("FAIL midframe_d2_com got %b want 1011", com); end
    vectors++; if (seg_7 !== 8'hA4) begin miscompares++; $display("FAIL midframe_d2_seg got %h want a4", seg_7); end
    go(64);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL f4_latch_ftick got %b want 1", frame_tick); end
    for (int d = 0; d < 4; d++) begin
      go(66 + 4 * d);
      vectors++;
      if (seg_7 !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL abcd_seg digit %0d got %h want %h", d, seg_7, exp_seg[d]);
      end
    end
  endtask

  task automatic test_dp_blink();
    dp_in = 4'b0100; blink_mask = 4'b0001;
    go(82);
    vectors++; if (seg_7 !== 8'hA1) begin miscompares++; $display("FAIL blink_d0_visible got %h want a1", seg_7); end
    go(90);
    vectors++; if (com !== 4'b1011) begin miscompares++; $display("FAIL dp_d2_com got %b want 1011", com); end
    vectors++; if (seg_7 !== 8'h03) begin miscompares++; $display("FAIL dp_d2_seg got %h want 03", seg_7); end
    go(94);
    vectors++; if (seg_7 !== 8'h88) begin miscompares++; $display("FAIL dp_d3_seg got %h want 88", seg_7); end
    blink_mask = 4'b1111;
    go(98);
    vectors++; if (seg_7 !== 8'hA1) begin miscompares++; $display("FAIL blink_all_d0 got %h want a1", seg_7); end
    go(102);
    vectors++; if (seg_7 !== 8'hC6) begin miscompares++; $display("FAIL blink_all_d1 got %h want c6", seg_7); end
    go(106);
    vectors++; if (com !== 4'b1011) begin miscompares++; $display("FAIL blink_d2_com got %b want 1011", com); end
    vectors++; if (seg_7 !== 8'hFF) begin miscompares++; $display("FAIL blink_d2_dp_override got %h want ff", seg_7); end
    go(110);
    vectors++; if (seg_7 !== 8'hFF) begin miscompares++; $display("FAIL blink_all_d3 got %h want ff", seg_7); end
    go(114);
    vectors++; if (seg_7 !== 8'hA1) begin miscompares++; $display("FAIL blink_d0_revisible got %h want a1", seg_7); end
  endtask

  task automatic test_reset_mid_scan();
    go(122);
    vectors++; if (com !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_d2_com got %b want 1011", com); end
    dp_in = 4'b0000; blink_mask = 4'b0000;
    reset_p = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (com !== 4'b1111) begin miscompares++; $display("FAIL midreset_com got %b want 1111", com); end
    vectors++; if (seg_7 !== 8'hFF) begin miscompares++; $display("FAIL midreset_seg got %h want ff", seg_7); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL midreset_ftick got %b want 0", frame_tick); end
    release_reset();
    go(2);
    vectors++; if (com !== 4'b1110) begin miscompares++; $display("FAIL restart_d0_com got %b want 1110", com); end
    vectors++; if (seg_7 !== 8'hC0) begin miscompares++; $display("FAIL restart_d0_seg got %h want c0", seg_7); end
    go(6);
    vectors++; if (com !== 4'b1101) begin miscompares++; $display("FAIL restart_d1_com got %b want 1101", com); end
    vectors++; if (seg_7 !== 8'hC0) begin miscompares++; $display("FAIL restart_d1_seg got %h want c0", seg_7); end
  endtask

  task automatic test_leading_zero();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
`ifdef FND_LEADING_ZERO_BLANK_EN
    exp_a = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
    exp_b = '{8'hC0, 8'hFF, 8'hFF, 8'h7F};
`else
    exp_a = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
    exp_b = '{8'hC0, 8'hC0, 8'hC0, 8'h40};
`endif
    value = 16'h0050; dp_in = 4'b0000; blink_mask = 4'b0000;
    apply_reset();
    release_reset();
    for (int d = 0; d < 4; d++) begin
      go(18 + 4 * d);
      vectors++;
      if (seg_7 !== exp_a[d]) begin
        miscompares++;
        $display("FAIL lz_0050 digit %0d got %h want %h", d, seg_7, exp_a[d]);
      end
      if (d == 1) begin
        value = 16'h0000;
        dp_in = 4'b1000;
      end
    end
    for (int d = 0; d < 4; d++) begin
      go(34 + 4 * d);
      vectors++;
      if (seg_7 !== exp_b[d]) begin
        miscompares++;
        $display("FAIL lz_0000 digit %0d got %h want %h", d, seg_7, exp_b[d]);
      end
    end
  endtask

  initial begin
    reset_p = 1'b1;
    value = '0; dp_in = '0; blink_mask = '0;
    test_reset();
    test_first_latch();
    test_guard();
    test_value_change();
    test_dp_blink();
    test_reset_mid_scan();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
